// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline control bundle between the core and the hazard unit
interface hazard_unit_if #(
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic [31:0]      instru_de;
  logic             dREN_ex;
  logic             regWr_ex;
  logic [4:0]       regDst_ex;
  logic             dREN_me;
  logic             dWEN_me;
  logic             branch_taken_ex;
  logic             halt_me;
  logic             pc_en;
  logic             fd_en;
  logic             de_en;
  logic             em_en;
  logic             mw_en;
  logic             fd_flush;
  logic             de_flush;
  logic             em_flush;
  logic             mw_flush;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  ihit, dhit, instru_de, dREN_ex, regWr_ex, regDst_ex,
           dREN_me, dWEN_me, branch_taken_ex, halt_me,
    output pc_en, fd_en, de_en, em_en, mw_en,
           fd_flush, de_flush, em_flush, mw_flush,
           halted, state, stall_cnt, flush_cnt
  );

  modport master (
    output ihit, dhit, instru_de, dREN_ex, regWr_ex, regDst_ex,
           dREN_me, dWEN_me, branch_taken_ex, halt_me,
    input  pc_en, fd_en, de_en, em_en, mw_en,
           fd_flush, de_flush, em_flush, mw_flush,
           halted, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall/flush controller for the 5-stage pipeline with perf counters
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic       CLK,
  input  logic       nRST,
  hazard_unit_if.slave hif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t           state_q, state_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [5:0] opcode_de, funct_de;
  logic [4:0] rs_de, rt_de;
  logic       uses_rt, is_jr, is_jump, mem_busy, load_use;
  logic       pc_en, fd_en, de_en, em_en, mw_en;
  logic       fd_flush, de_flush, em_flush, mw_flush;
  logic       flush_inc, stall_inc;

  assign opcode_de = hif.instru_de[31:26];
  assign funct_de  = hif.instru_de[5:0];
  assign rs_de     = hif.instru_de[25:21];
  assign rt_de     = hif.instru_de[20:16];
  assign uses_rt   = (opcode_de == OP_RTYPE) || (opcode_de == OP_BEQ) ||
                     (opcode_de == OP_BNE)   || (opcode_de == OP_SW);
  assign is_jr     = (opcode_de == OP_RTYPE) && (funct_de == FN_JR);
  assign is_jump   = (opcode_de == OP_J) || (opcode_de == OP_JAL) || is_jr;
  assign mem_busy  = (hif.dREN_me || hif.dWEN_me) && !hif.dhit;
  assign load_use  = hif.dREN_ex && hif.regWr_ex && (hif.regDst_ex != 5'd0) &&
                     ((rs_de == hif.regDst_ex) || (uses_rt && (rt_de == hif.regDst_ex)));

  // While in LD_STALL the execute stage holds the bubble we just inserted, so
  // load_use is ignored there to guarantee a single stall cycle.
  always_comb begin
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    de_en     = 1'b1;
    em_en     = 1'b1;
    mw_en     = 1'b1;
    fd_flush  = 1'b0;
    de_flush  = 1'b0;
    em_flush  = 1'b0;
    mw_flush  = 1'b0;
    flush_inc = 1'b0;
    state_d   = RUN;
    if (state_q == HALTED || hif.halt_me) begin
      pc_en   = 1'b0;
      fd_en   = 1'b0;
      de_en   = 1'b0;
      em_en   = 1'b0;
      mw_en   = 1'b0;
      state_d = HALTED;
    end else if (mem_busy) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_en    = 1'b0;
      em_en    = 1'b0;
      mw_flush = 1'b1;
      state_d  = MEM_WAIT;
    end else if (hif.branch_taken_ex) begin
      fd_flush  = 1'b1;
      de_flush  = 1'b1;
      flush_inc = 1'b1;
    end else if (load_use && state_q != LD_STALL) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_flush = 1'b1;
      state_d  = LD_STALL;
    end else if (is_jump && hif.ihit) begin
      fd_flush  = 1'b1;
      flush_inc = 1'b1;
    end else if (!hif.ihit) begin
      pc_en    = 1'b0;
      fd_flush = 1'b1;
    end
  end

  assign halted_d  = halted_q || (state_d == HALTED);
  assign stall_inc = !pc_en && (state_q != HALTED);

  // Counters saturate at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= RUN;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hif.pc_en     = pc_en;
  assign hif.fd_en     = fd_en;
  assign hif.de_en     = de_en;
  assign hif.em_en     = em_en;
  assign hif.mw_en     = mw_en;
  assign hif.fd_flush  = fd_flush;
  assign hif.de_flush  = de_flush;
  assign hif.em_flush  = em_flush;
  assign hif.mw_flush  = mw_flush;
  assign hif.halted    = halted_q;
  assign hif.state     = state_q;
  assign hif.stall_cnt = stall_cnt_q;
  assign hif.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed plus randomized checks of hazard_unit against a reference model
module tb_hazard_unit;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic nRST;
  int   n_tests = 0;
  int   n_fail  = 0;

  hazard_unit_if #(.CNT_W(CNT_W)) hif ();
  hazard_unit #(.CNT_W(CNT_W)) dut (.CLK(CLK), .nRST(nRST), .hif(hif));

  always #5 CLK = ~CLK;

  int m_state, m_stall, m_flush, m_halted;
  bit e_pc, e_fd, e_de, e_em, e_mw, e_fdf, e_def, e_emf, e_mwf, e_finc;
  int e_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    logic [31:0] w;
    w = {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
    return w;
  endfunction

  // Expected control for the current inputs, from the priority rules.
  task automatic model_eval();
    int op, fn, rs, rt;
    bit busy, lu, jump, rt_used;
    op = int'(hif.instru_de >> 26);
    fn = int'(hif.instru_de & 32'h3f);
    rs = int'((hif.instru_de >> 21) & 32'h1f);
    rt = int'((hif.instru_de >> 16) & 32'h1f);
    rt_used = (op == 0 || op == 4 || op == 5 || op == 43);
    jump = (op == 2 || op == 3 || (op == 0 && fn == 8));
    busy = (hif.dREN_me || hif.dWEN_me) && !hif.dhit;
    lu = hif.dREN_ex && hif.regWr_ex && hif.regDst_ex != 0 &&
         (rs == int'(hif.regDst_ex) || (rt_used && rt == int'(hif.regDst_ex)));
    {e_pc, e_fd, e_de, e_em, e_mw} = 5'b11111;
    {e_fdf, e_def, e_emf, e_mwf} = 4'b0000;
    e_finc = 0;
    e_next = 0;
    if (m_state == 3 || hif.halt_me) begin
      {e_pc, e_fd, e_de, e_em, e_mw} = 5'b00000;
      e_next = 3;
    end else if (busy) begin
      {e_pc, e_fd, e_de, e_em} = 4'b0000;
      e_mwf = 1;
      e_next = 2;
    end else if (hif.branch_taken_ex) begin
      e_fdf = 1; e_def = 1; e_finc = 1;
    end else if (lu && m_state != 1) begin
      e_pc = 0; e_fd = 0; e_def = 1;
      e_next = 1;
    end else if (jump && hif.ihit) begin
      e_fdf = 1; e_finc = 1;
    end else if (!hif.ihit) begin
      e_pc = 0; e_fdf = 1;
    end
  endtask

  task automatic mid(input string tag);
    #4;
    model_eval();
    if (nRST) begin
      chk({tag, ".pc_en"}, hif.pc_en, e_pc);
      chk({tag, ".en"}, {hif.fd_en, hif.de_en, hif.em_en, hif.mw_en}, {e_fd, e_de, e_em, e_mw});
      chk({tag, ".flush"}, {hif.fd_flush, hif.de_flush, hif.em_flush, hif.mw_flush},
          {e_fdf, e_def, e_emf, e_mwf});
    end
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    if (!nRST) begin
      m_state = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pc && m_state != 3 && m_stall < MAXC) m_stall++;
      if (e_finc && m_flush < MAXC) m_flush++;
      if (e_next == 3) m_halted = 1;
      m_state = e_next;
    end
    #1;
    chk({tag, ".state"}, hif.state, m_state);
    chk({tag, ".halted"}, hif.halted, m_halted);
    chk({tag, ".stall_cnt"}, hif.stall_cnt, m_stall);
    chk({tag, ".flush_cnt"}, hif.flush_cnt, m_flush);
  endtask

  task automatic idle_inputs();
    hif.ihit = 1; hif.dhit = 0; hif.instru_de = 32'd0;
    hif.dREN_ex = 0; hif.regWr_ex = 0; hif.regDst_ex = 5'd0;
    hif.dREN_me = 0; hif.dWEN_me = 0; hif.branch_taken_ex = 0; hif.halt_me = 0;
  endtask

  task automatic do_reset();
    nRST = 0; idle_inputs();
    mid("rst"); tick("rst");
    nRST = 1;
  endtask

  task automatic load_use_inputs(input int dst);
    hif.dREN_ex = 1; hif.regWr_ex = 1; hif.regDst_ex = dst[4:0];
    hif.instru_de = rtype(5, 1, 6, 32);
  endtask

  initial begin
    int ops[9];
    ops = '{0, 0, 4, 5, 43, 35, 2, 3, 8};
    nRST = 0; idle_inputs();
    m_state = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    @(posedge CLK); @(posedge CLK); #1;
    chk("reset.state", hif.state, 2'd0);
    chk("reset.halted", hif.halted, 1'b0);
    chk("reset.stall_cnt", hif.stall_cnt, 0);
    chk("reset.flush_cnt", hif.flush_cnt, 0);
    nRST = 1;

    load_use_inputs(5);
    mid("ldu"); chk("ldu.pc_en0", hif.pc_en, 1'b0); chk("ldu.de_flush1", hif.de_flush, 1'b1);
    tick("ldu"); chk("ldu.state1", hif.state, 2'd1);
    hif.dREN_ex = 0;
    mid("ldu2"); tick("ldu2");
    chk("ldu2.state0", hif.state, 2'd0); chk("ldu2.stall1", hif.stall_cnt, 1);

    do_reset();
    load_use_inputs(0); hif.instru_de = rtype(0, 0, 6, 32);
    mid("ldr0"); chk("ldr0.pc_en1", hif.pc_en, 1'b1);
    tick("ldr0"); chk("ldr0.state0", hif.state, 2'd0); chk("ldr0.stall0", hif.stall_cnt, 0);

    do_reset();
    hif.dWEN_me = 1; hif.dhit = 0;
    for (int i = 0; i < 3; i++) begin
      mid("sw"); chk("sw.mw_flush1", hif.mw_flush, 1'b1); chk("sw.pc_en0", hif.pc_en, 1'b0);
      tick("sw"); chk("sw.state2", hif.state, 2'd2);
    end
    hif.dhit = 1;
    mid("swdone"); tick("swdone");
    chk("swdone.state0", hif.state, 2'd0); chk("swdone.stall3", hif.stall_cnt, 3);

    do_reset();
    load_use_inputs(5); hif.branch_taken_ex = 1;
    mid("br"); chk("br.flushes", {hif.fd_flush, hif.de_flush, hif.pc_en}, 3'b111);
    tick("br"); chk("br.flush1", hif.flush_cnt, 1); chk("br.state0", hif.state, 2'd0);

    do_reset();
    hif.halt_me = 1;
    mid("halt"); tick("halt");
    for (int i = 0; i < 5; i++) begin
      hif.ihit = 1'($urandom); hif.dhit = 1'($urandom); hif.halt_me = 1'($urandom);
      hif.branch_taken_ex = 1'($urandom); hif.dWEN_me = 1'($urandom);
      mid("halted"); chk("halted.pc_en0", hif.pc_en, 1'b0);
      tick("halted"); chk("halted.state3", hif.state, 2'd3); chk("halted.h1", hif.halted, 1'b1);
    end
    do_reset();
    chk("unhalt.state0", hif.state, 2'd0); chk("unhalt.h0", hif.halted, 1'b0);
    chk("unhalt.cnt0", {hif.stall_cnt, hif.flush_cnt}, 0);

    hif.instru_de = rtype(31, 0, 0, 8); hif.ihit = 0;
    mid("jr_miss"); chk("jr_miss.pc_fd", {hif.pc_en, hif.fd_flush}, 2'b01);
    tick("jr_miss"); chk("jr_miss.flush0", hif.flush_cnt, 0);
    hif.ihit = 1;
    mid("jr_hit"); chk("jr_hit.fd_flush1", hif.fd_flush, 1'b1);
    tick("jr_hit"); chk("jr_hit.flush1", hif.flush_cnt, 1);

    for (int i = 0; i < 600; i++) begin
      int op;
      op = ops[$urandom_range(0, 8)];
      nRST = ($urandom_range(0, 59) != 0);
      hif.instru_de = {op[5:0], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom), 5'($urandom),
                       ($urandom_range(0, 1) != 0) ? 6'd8 : 6'd32};
      hif.ihit = ($urandom_range(0, 3) != 0);
      hif.dhit = 1'($urandom);
      hif.dREN_ex = 1'($urandom); hif.regWr_ex = ($urandom_range(0, 3) != 0);
      hif.regDst_ex = 5'($urandom_range(0, 3));
      hif.dREN_me = ($urandom_range(0, 3) == 0); hif.dWEN_me = ($urandom_range(0, 3) == 0);
      hif.branch_taken_ex = ($urandom_range(0, 5) == 0);
      hif.halt_me = ($urandom_range(0, 79) == 0);
      mid("rand"); tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard/stall controller for the 5-stage MIPS core; sits beside the forwarding unit and drives the enable/flush of the PC and the four latches (fetch/decode, decode/execute, execute/mem, mem/writeback).
- Resolves load-use stalls, jr-on-load stalls, branch/jump flushes, i/d-memory wait, and sticky halt.
- Counts stall and flush cycles for performance reporting.

Parameters:
CNT_W, 32, width of the stall_cnt and flush_cnt counters

Ports:
CLK  in  1  system clock
nRST  in  1  synchronous active-low reset, sampled on rising CLK
ihit  in  1  instruction fetch completed this cycle
dhit  in  1  data access completed this cycle
instru_de  in  32  instruction in decode
dREN_ex  in  1  execute-stage instruction is a load
regWr_ex  in  1  execute-stage writes a register
regDst_ex  in  5  execute-stage destination register
dREN_me  in  1  mem-stage load pending
dWEN_me  in  1  mem-stage store pending
branch_taken_ex  in  1  beq/bne resolved taken in execute
halt_me  in  1  halt opcode reached mem stage
pc_en  out  1  PC update enable
fd_en, de_en, em_en, mw_en  out  1 each  latch enables
fd_flush, de_flush, em_flush, mw_flush  out  1 each  latch clears to bubble; a flush overrides the enable
halted  out  1  sticky halt
state  out  2  FSM state: 0 RUN, 1 LD_STALL, 2 MEM_WAIT, 3 HALTED
stall_cnt  out  CNT_W  cycles with pc_en=0 outside HALTED
flush_cnt  out  CNT_W  cycles with fd_flush=1 due to branch or jump

Behaviour:
- Reset (nRST=0 at the edge): state=RUN, halted=0, both counters 0. All enables and flushes are driven from the next-state logic; no output is asserted in the reset cycle except via state=RUN.
- Decode fields: rs_de=instru_de[25:21], rt_de=instru_de[20:16]. uses_rt is true for opcode 0 (R-type), beq 000100, bne 000101, sw 101011. A jr is opcode 0 with funct 001000.
- mem_busy = (dREN_me | dWEN_me) & ~dhit.
- load_use = dREN_ex & regWr_ex & regDst_ex!=0 & (rs_de==regDst_ex | (uses_rt & rt_de==regDst_ex)). This term covers a jr that depends on a load.
- Combinational priority, highest first:
  1. HALTED: all enables 0, no flush.
  2. halt_me: next state HALTED; all enables 0.
  3. mem_busy: next state MEM_WAIT; pc/fd/de/em enables 0; mw_flush=1 so a bubble goes to WB.
  4. branch_taken_ex: all enables 1; fd_flush=1, de_flush=1; flush_cnt+1.
  5. load_use: next state LD_STALL; pc_en=0, fd_en=0, de_flush=1; em/mw advance.
  6. j 000010 / jal 000011 / jr in decode with ~ihit=0: fd_flush=1; flush_cnt+1.
  7. ~ihit: pc_en=0, fd_flush=1; downstream advances.
  8. Otherwise all enables 1, no flush.
- FSM transitions:
  - LD_STALL returns to RUN after exactly one cycle unless a higher-priority condition holds.
  - MEM_WAIT holds while mem_busy and exits to RUN on dhit.
  - HALTED is left only by reset.
- Data access wins arbitration: while mem_busy, ihit is ignored.
- Counters saturate at all-ones and do not wrap. stall_cnt increments once per cycle when pc_en=0 and state!=HALTED.
- Reset mid-stall returns the FSM to RUN immediately and clears both counters.
- When branch_taken_ex and load_use are both true in the same cycle, the branch wins (item 4 before item 5); the load-use instruction is flushed.

Test Plan:
- Load r5 then add r6,r5,r1 back-to-back, ihit=1 -> one cycle with pc_en=0, de_flush=1, state=1; the next cycle state=0; stall_cnt=1.
- Load r0 then add using r0 -> no stall; state stays 0; stall_cnt=0.
- Store in mem with dhit=0 for 3 cycles, then 1 -> state=2 for 3 cycles, mw_flush=1 each cycle, enables 0; returns to RUN; stall_cnt=3.
- branch_taken_ex=1 while a load-use is present in decode -> fd_flush=1, de_flush=1, pc_en=1; flush_cnt=1; no LD_STALL.
- halt_me=1, then inputs toggled for 5 cycles -> halted=1, state=3, all enables 0; nRST=0 for one edge -> state=0, halted=0, counters 0.
- ihit=0 with jr r31 in decode -> pc_en=0, fd_flush=1, flush_cnt unchanged; with ihit=1 the same jr gives fd_flush=1, flush_cnt+1.
